regfile_writeback_queue: RTL

Writeback-side initiator for the processor's 32x32 register file write port. Accepts completed results (destination index plus data) from the writeback stage through a valid/ready handshake and buffers them in a small in-order queue. Retires one result per cycle onto the register file's write-enable, write-address and write-data inputs. Exposes a youngest-match lookup so decode can bypass values that are queued but not yet written.

---
 rtl/regfile_writeback_queue_pkg.sv | 14 +
 rtl/regfile_writeback_queue_if.sv | 36 +++
 rtl/regfile_writeback_queue_wbq_match.sv | 33 +++
 rtl/regfile_writeback_queue.sv | 94 +++++++++
 4 files changed

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared defaults and types for the register-file writeback queue.
package regfile_writeback_queue_pkg;

    localparam int unsigned WBQ_DEPTH = 4;
    localparam int unsigned WBQ_AW    = 5;
    localparam int unsigned WBQ_DW    = 32;
    localparam int unsigned WBQ_CW    = $clog2(WBQ_DEPTH) + 1;

    typedef struct packed {
        logic [WBQ_AW-1:0] rd;
        logic [WBQ_DW-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Writeback, register-file write port and bypass lookup signals of the queue.
interface regfile_writeback_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          rf_hold;
    logic          rf_wr;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] q_rs;
    logic [AW-1:0] q_rt;
    logic          hit_a;
    logic [DW-1:0] data_a;
    logic          hit_b;
    logic [DW-1:0] data_b;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  wb_valid, wb_rd, wb_data, rf_hold, q_rs, q_rt,
        output wb_ready, rf_wr, rf_rw, rf_data, hit_a, data_a, hit_b, data_b, count, empty
    );

    modport master (
        output wb_valid, wb_rd, wb_data, rf_hold, q_rs, q_rt,
        input  wb_ready, rf_wr, rf_rw, rf_data, hit_a, data_a, hit_b, data_b, count, empty
    );

endinterface

// File: rtl/regfile_writeback_queue_wbq_match.sv
// Youngest-match search over the occupied queue entries for one lookup index.
module wbq_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic [AW-1:0]            i_rd   [DEPTH],
    input  logic [DW-1:0]            i_data [DEPTH],
    input  logic [DEPTH-1:0]         i_occ,
    input  logic [$clog2(DEPTH)-1:0] i_tail,
    input  logic [AW-1:0]            i_q,
    output logic                     o_hit,
    output logic [DW-1:0]            o_data
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] w_idx;

    // Walk oldest-to-youngest (slot tail-DEPTH .. tail-1) so the last match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            w_idx = i_tail - PW'(k);
            if (i_occ[w_idx] && (i_rd[w_idx] == i_q)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with bypass lookup.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH = WBQ_DEPTH,
    parameter int unsigned AW    = WBQ_AW,
    parameter int unsigned DW    = WBQ_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_writeback_queue_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]    r_rd   [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_occ;
    logic [PW-1:0]    w_off;

    assign w_empty = (r_count == '0);
    assign w_ready = (r_count < CW'(DEPTH));
    assign w_push  = bus.wb_valid && w_ready;
    assign w_pop   = !w_empty && !bus.rf_hold;

    assign bus.wb_ready = w_ready;
    assign bus.rf_wr    = w_pop;
    assign bus.rf_rw    = w_empty ? '0 : r_rd[r_head];
    assign bus.rf_data  = w_empty ? '0 : r_data[r_head];
    assign bus.count    = r_count;
    assign bus.empty    = w_empty;

    // A slot is occupied when its distance from head is below the occupancy count.
    always_comb begin
        w_occ = '0;
        w_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off    = PW'(i) - r_head;
            w_occ[i] = (CW'(w_off) < r_count);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= bus.wb_rd;
            r_data[r_tail] <= bus.wb_data;
        end
    end

    wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
        .i_rd   (r_rd),
        .i_data (r_data),
        .i_occ  (w_occ),
        .i_tail (r_tail),
        .i_q    (bus.q_rs),
        .o_hit  (bus.hit_a),
        .o_data (bus.data_a)
    );

    wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
        .i_rd   (r_rd),
        .i_data (r_data),
        .i_occ  (w_occ),
        .i_tail (r_tail),
        .i_q    (bus.q_rt),
        .o_hit  (bus.hit_b),
        .o_data (bus.data_b)
    );

endmodule
